// File: rtl/tm_pio_pkg.sv
// Shared types and constants for the traffic-manager PIO target fabric.
// Target indices mirror the TM memory map: queue association, then 14 memories per port.
package tm_pio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_UNMAP = 2'd2,
    ST_RESP  = 2'd3
  } tm_pio_state_e;

  localparam logic [31:0] TM_PIO_ERR_DATA = 32'hDEAD_BEEF;

  localparam int TM_NUM_PORTS     = 4;
  localparam int TM_MEMS_PER_PORT = 14;
  localparam int TM_NUM_TGT       = 1 + TM_NUM_PORTS * TM_MEMS_PER_PORT;

  localparam int TM_TGT_QUEUE_ASSOCIATION = 0;

  // Per-port memory offsets, relative to the port base 1 + 14*port
  localparam int TM_MEM_QUEUE_PROFILE  = 0;
  localparam int TM_MEM_WDRR_QUANTUM   = 1;
  localparam int TM_MEM_CIR            = 2;
  localparam int TM_MEM_EIR            = 3;
  localparam int TM_MEM_WDRR_SCH_CTRL  = 4;
  localparam int TM_MEM_FILL_TB_DST    = 5;
  localparam int TM_MEM_PRI_SCH_CTRL0  = 6;
  localparam int TM_NUM_PRI            = 8;

  function automatic int tm_tgt_idx(input int port, input int mem);
    return 1 + port * TM_MEMS_PER_PORT + mem;
  endfunction

  function automatic int tm_pri_sch_ctrl_idx(input int port, input int pri);
    return tm_tgt_idx(port, TM_MEM_PRI_SCH_CTRL0 + pri);
  endfunction

endpackage

// File: rtl/tm_pio_rdmux.sv
// NUM_TGT:1 ack / read-data selector driven by the latched target index.
// Out-of-range indices select nothing (ack 0, data 0).
module tm_pio_rdmux
  import tm_pio_pkg::*;
#(
  parameter int NUM_TGT   = 57,
  parameter int SEL_BITS  = 6,
  parameter int PIO_NBITS = 32
) (
  input  logic [SEL_BITS-1:0]          idx,
  input  logic [NUM_TGT-1:0]           tgt_ack,
  input  logic [NUM_TGT*PIO_NBITS-1:0] tgt_rdata,
  output logic                         sel_ack,
  output logic [PIO_NBITS-1:0]         sel_rdata
);

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (idx == SEL_BITS'(i)) begin
        sel_ack   = tgt_ack[i];
        sel_rdata = tgt_rdata[i*PIO_NBITS +: PIO_NBITS];
      end
    end
  end

endmodule

// File: rtl/tm_pio_fabric.sv
// PIO target fabric: decodes a register access to one of NUM_TGT targets, holds the
// select until the target acks (or times out) and returns a one-divided-period response.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no access in flight; accepts a request on any clk edge
// ST_WAIT  | tgt_ms held one-hot; waiting for ack or timeout (clk_div)
// ST_UNMAP | unmapped index; error response on next clk_div edge
// ST_RESP  | pio_ack high; cleared on next clk_div edge
module tm_pio_fabric
  import tm_pio_pkg::*;
#(
  parameter int                   NUM_TGT     = 57,
  parameter int                   SEL_BITS    = 6,
  parameter int                   SEL_LSB     = 16,
  parameter int                   PIO_NBITS   = 32,
  parameter int                   TIMEOUT_CYC = 255,
  parameter logic [PIO_NBITS-1:0] ERR_DATA    = PIO_NBITS'(TM_PIO_ERR_DATA)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_div,
  input  logic                         reg_bs,
  input  logic                         reg_wr,
  input  logic                         reg_rd,
  input  logic [PIO_NBITS-1:0]         reg_addr,
  input  logic [PIO_NBITS-1:0]         reg_din,
  input  logic [NUM_TGT-1:0]           tgt_ack,
  input  logic [NUM_TGT*PIO_NBITS-1:0] tgt_rdata,
  output logic [NUM_TGT-1:0]           tgt_ms,
  output logic                         pio_ack,
  output logic                         pio_rvalid,
  output logic [PIO_NBITS-1:0]         pio_rdata,
  output logic                         pio_err,
  output logic [PIO_NBITS-1:0]         err_addr,
  output logic [15:0]                  err_cnt,
  output logic                         overrun
);

  localparam int                  CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [SEL_BITS:0]   TGT_LIMIT = (SEL_BITS+1)'(NUM_TGT);

  tm_pio_state_e         state, state_nxt;
  logic [SEL_BITS-1:0]   idx_q;
  logic                  is_read_q;
  logic [PIO_NBITS-1:0]  addr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  req;
  logic                  in_map;
  logic [SEL_BITS-1:0]   idx_in;
  logic [NUM_TGT-1:0]    sel_dec;
  logic                  sel_ack;
  logic [PIO_NBITS-1:0]  sel_rdata;

  logic accept, done_ok, done_err, resp_clr, cnt_inc, busy_req;

  // Write data is routed straight to the targets outside this block.
  logic unused_din;
  assign unused_din = ^reg_din;

  assign req    = reg_bs & (reg_rd | reg_wr);
  assign idx_in = reg_addr[SEL_LSB +: SEL_BITS];
  assign in_map = ({1'b0, idx_in} < TGT_LIMIT);

  always_comb begin
    sel_dec = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      sel_dec[i] = (idx_in == SEL_BITS'(i));
    end
  end

  tm_pio_rdmux #(
    .NUM_TGT   (NUM_TGT),
    .SEL_BITS  (SEL_BITS),
    .PIO_NBITS (PIO_NBITS)
  ) u_rdmux (
    .idx       (idx_q),
    .tgt_ack   (tgt_ack),
    .tgt_rdata (tgt_rdata),
    .sel_ack   (sel_ack),
    .sel_rdata (sel_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    resp_clr  = 1'b0;
    cnt_inc   = 1'b0;
    busy_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = in_map ? ST_WAIT : ST_UNMAP;
        end
      end
      ST_WAIT: begin
        busy_req = req;
        // Ack takes priority over an expiring timeout on the same edge
        if (clk_div) begin
          if (sel_ack) begin
            done_ok   = 1'b1;
            state_nxt = ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            done_err  = 1'b1;
            state_nxt = ST_RESP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_UNMAP: begin
        busy_req = req;
        if (clk_div) begin
          done_err  = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        busy_req = req;
        if (clk_div) begin
          resp_clr  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      tgt_ms     <= '0;
      pio_ack    <= 1'b0;
      pio_rvalid <= 1'b0;
      pio_rdata  <= '0;
      pio_err    <= 1'b0;
      err_addr   <= '0;
      err_cnt    <= '0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        idx_q     <= idx_in;
        is_read_q <= reg_rd;
        addr_q    <= reg_addr;
        cnt_q     <= '0;
        tgt_ms    <= in_map ? sel_dec : '0;
      end
      if (cnt_inc)  cnt_q   <= cnt_q + 1'b1;
      if (busy_req) overrun <= 1'b1;
      if (done_ok) begin
        pio_ack    <= 1'b1;
        pio_rvalid <= is_read_q;
        pio_rdata  <= is_read_q ? sel_rdata : '0;
        pio_err    <= 1'b0;
        tgt_ms     <= '0;
      end
      if (done_err) begin
        pio_ack    <= 1'b1;
        pio_err    <= 1'b1;
        pio_rvalid <= is_read_q;
        pio_rdata  <= is_read_q ? ERR_DATA : '0;
        err_addr   <= addr_q;
        tgt_ms     <= '0;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (resp_clr) begin
        pio_ack    <= 1'b0;
        pio_rvalid <= 1'b0;
        pio_err    <= 1'b0;
        pio_rdata  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tm_pio_fabric.sv
// Directed bench for tm_pio_fabric: clk_div every 4th clk, TIMEOUT_CYC = 8.
module tb_tm_pio_fabric;

  localparam int NT = 57;
  localparam int PW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clk_div = 1'b0;
  logic            reg_bs = 1'b0;
  logic            reg_wr = 1'b0;
  logic            reg_rd = 1'b0;
  logic [PW-1:0]   reg_addr = '0;
  logic [PW-1:0]   reg_din = '0;
  logic [NT-1:0]   tgt_ack = '0;
  logic [NT*PW-1:0] tgt_rdata = '0;
  logic [NT-1:0]   tgt_ms;
  logic            pio_ack, pio_rvalid, pio_err, overrun;
  logic [PW-1:0]   pio_rdata, err_addr;
  logic [15:0]     err_cnt;

  int checks = 0;
  int failures = 0;
  int div_ph = 0;

  tm_pio_fabric #(
    .NUM_TGT(NT), .SEL_BITS(6), .SEL_LSB(16), .PIO_NBITS(PW), .TIMEOUT_CYC(8),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .reg_bs(reg_bs), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_din(reg_din), .tgt_ack(tgt_ack),
    .tgt_rdata(tgt_rdata), .tgt_ms(tgt_ms), .pio_ack(pio_ack), .pio_rvalid(pio_rvalid),
    .pio_rdata(pio_rdata), .pio_err(pio_err), .err_addr(err_addr), .err_cnt(err_cnt),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div_ph = (div_ph + 1) % 4;
    clk_div = (div_ph == 0);
  end

  // Stops just before the next posedge that has clk_div high.
  task automatic next_div();
    bit found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk); #1;
      if (clk_div) found = 1'b1;
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL next_div: clk_div=%0b required 1 within 16 cycles", clk_div);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [PW-1:0] addr);
    reg_bs = 1'b1; reg_rd = rd; reg_wr = wr; reg_addr = addr;
    tick();
    reg_bs = 1'b0; reg_rd = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({tgt_ms, pio_ack, pio_rvalid, pio_rdata, pio_err, err_addr, err_cnt, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: tgt_ms=%h ack=%b rvalid=%b rdata=%h err=%b err_addr=%h err_cnt=%0d overrun=%b required all 0",
               tgt_ms, pio_ack, pio_rvalid, pio_rdata, pio_err, err_addr, err_cnt, overrun);
    end
    rst = 1'b0;
    tick();
    reg_rd = 1'b1; reg_addr = 32'h0002_0000;
    tick();
    reg_rd = 1'b0;
    checks++;
    if (tgt_ms !== '0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL no_bs_ignored: tgt_ms=%h overrun=%b required 0 0", tgt_ms, overrun);
    end
  endtask

  task automatic test_read();
    logic [NT-1:0] exp_ms;
    exp_ms = '0; exp_ms[2] = 1'b1;
    tgt_rdata[2*PW +: PW] = 32'h1234_5678;
    tgt_rdata[3*PW +: PW] = 32'hAAAA_5555;
    issue(1'b1, 1'b0, 32'h0002_0000);
    checks++;
    if (tgt_ms !== exp_ms) begin
      failures++; $display("FAIL read_sel: tgt_ms=%h required %h", tgt_ms, exp_ms);
    end
    next_div(); tick();
    checks++;
    if (tgt_ms !== exp_ms || pio_ack !== 1'b0) begin
      failures++; $display("FAIL read_held: tgt_ms=%h ack=%b required %h 0", tgt_ms, pio_ack, exp_ms);
    end
    next_div();
    tgt_ack[2] = 1'b1;
    tick();
    tgt_ack = '0;
    checks++;
    if (pio_ack !== 1'b1 || pio_rvalid !== 1'b1 || pio_rdata !== 32'h1234_5678 ||
        pio_err !== 1'b0 || tgt_ms !== '0) begin
      failures++;
      $display("FAIL read_resp: ack=%b rvalid=%b rdata=%h err=%b tgt_ms=%h required 1 1 12345678 0 0",
               pio_ack, pio_rvalid, pio_rdata, pio_err, tgt_ms);
    end
    next_div();
    checks++;
    if (pio_ack !== 1'b1) begin
      failures++; $display("FAIL read_ack_hold: ack=%b required 1", pio_ack);
    end
    tick();
    checks++;
    if (pio_ack !== 1'b0 || pio_rvalid !== 1'b0 || pio_rdata !== '0) begin
      failures++;
      $display("FAIL read_clear: ack=%b rvalid=%b rdata=%h required 0 0 0", pio_ack, pio_rvalid, pio_rdata);
    end
  endtask

  task automatic test_write();
    logic [NT-1:0] exp_ms;
    exp_ms = '0; exp_ms[56] = 1'b1;
    tgt_rdata[56*PW +: PW] = 32'hCAFE_0056;
    reg_din = 32'h5A5A_0001;
    issue(1'b0, 1'b1, 32'h0038_0000);
    checks++;
    if (tgt_ms !== exp_ms) begin
      failures++; $display("FAIL write_sel: tgt_ms=%h required %h", tgt_ms, exp_ms);
    end
    next_div();
    tgt_ack[56] = 1'b1;
    tick();
    tgt_ack = '0;
    checks++;
    if (pio_ack !== 1'b1 || pio_rvalid !== 1'b0 || pio_rdata !== '0 || pio_err !== 1'b0 || tgt_ms !== '0) begin
      failures++;
      $display("FAIL write_resp: ack=%b rvalid=%b rdata=%h err=%b tgt_ms=%h required 1 0 0 0 0",
               pio_ack, pio_rvalid, pio_rdata, pio_err, tgt_ms);
    end
    next_div(); tick();
  endtask

  task automatic test_unmapped();
    issue(1'b1, 1'b0, 32'h003C_0000);
    checks++;
    if (tgt_ms !== '0) begin
      failures++; $display("FAIL unmap_sel: tgt_ms=%h required 0", tgt_ms);
    end
    next_div(); tick();
    checks++;
    if (pio_ack !== 1'b1 || pio_err !== 1'b1 || pio_rvalid !== 1'b1 || pio_rdata !== 32'hDEAD_BEEF ||
        err_addr !== 32'h003C_0000 || err_cnt !== 16'd1 || tgt_ms !== '0) begin
      failures++;
      $display("FAIL unmap_resp: ack=%b err=%b rvalid=%b rdata=%h err_addr=%h err_cnt=%0d required 1 1 1 deadbeef 003c0000 1",
               pio_ack, pio_err, pio_rvalid, pio_rdata, err_addr, err_cnt);
    end
    next_div(); tick();
  endtask

  task automatic test_timeout();
    logic [NT-1:0] exp_ms;
    exp_ms = '0; exp_ms[5] = 1'b1;
    tgt_ack = '1; tgt_ack[5] = 1'b0;
    issue(1'b1, 1'b0, 32'h0005_0000);
    for (int k = 1; k <= 7; k++) begin next_div(); tick(); end
    checks++;
    if (pio_ack !== 1'b0 || tgt_ms !== exp_ms) begin
      failures++; $display("FAIL timeout_pre: ack=%b tgt_ms=%h required 0 %h", pio_ack, tgt_ms, exp_ms);
    end
    next_div(); tick();
    tgt_ack = '0;
    checks++;
    if (pio_ack !== 1'b1 || pio_err !== 1'b1 || pio_rvalid !== 1'b1 || pio_rdata !== 32'hDEAD_BEEF ||
        err_addr !== 32'h0005_0000 || err_cnt !== 16'd2 || tgt_ms !== '0) begin
      failures++;
      $display("FAIL timeout_resp: ack=%b err=%b rvalid=%b rdata=%h err_addr=%h err_cnt=%0d tgt_ms=%h required 1 1 1 deadbeef 00050000 2 0",
               pio_ack, pio_err, pio_rvalid, pio_rdata, err_addr, err_cnt, tgt_ms);
    end
    next_div(); tick();

    tgt_rdata[5*PW +: PW] = 32'h0BAD_F00D;
    issue(1'b1, 1'b0, 32'h0005_0000);
    for (int k = 1; k <= 7; k++) begin next_div(); tick(); end
    next_div();
    tgt_ack[5] = 1'b1;
    tick();
    tgt_ack = '0;
    checks++;
    if (pio_ack !== 1'b1 || pio_err !== 1'b0 || pio_rdata !== 32'h0BAD_F00D || err_cnt !== 16'd2) begin
      failures++;
      $display("FAIL ack_vs_timeout: ack=%b err=%b rdata=%h err_cnt=%0d required 1 0 0badf00d 2",
               pio_ack, pio_err, pio_rdata, err_cnt);
    end
    next_div(); tick();
  endtask

  task automatic test_overrun();
    logic [NT-1:0] exp_ms;
    exp_ms = '0; exp_ms[7] = 1'b1;
    tgt_rdata[7*PW +: PW] = 32'h7777_0007;
    tgt_rdata[9*PW +: PW] = 32'h9999_0009;
    issue(1'b1, 1'b0, 32'h0007_0000);
    tick();
    issue(1'b1, 1'b0, 32'h0009_0000);
    checks++;
    if (overrun !== 1'b1 || tgt_ms !== exp_ms) begin
      failures++; $display("FAIL overrun_set: overrun=%b tgt_ms=%h required 1 %h", overrun, tgt_ms, exp_ms);
    end
    next_div();
    tgt_ack[7] = 1'b1;
    tick();
    tgt_ack = '0;
    checks++;
    if (pio_ack !== 1'b1 || pio_err !== 1'b0 || pio_rdata !== 32'h7777_0007) begin
      failures++;
      $display("FAIL overrun_first_done: ack=%b err=%b rdata=%h required 1 0 77770007", pio_ack, pio_err, pio_rdata);
    end
    next_div(); tick();
    checks++;
    if (overrun !== 1'b1 || tgt_ms !== '0) begin
      failures++; $display("FAIL overrun_sticky: overrun=%b tgt_ms=%h required 1 0", overrun, tgt_ms);
    end
  endtask

  task automatic test_rd_wr_both();
    tgt_rdata[10*PW +: PW] = 32'h1010_ABCD;
    issue(1'b1, 1'b1, 32'h000A_0000);
    next_div();
    tgt_ack[10] = 1'b1;
    tick();
    tgt_ack = '0;
    checks++;
    if (pio_ack !== 1'b1 || pio_rvalid !== 1'b1 || pio_rdata !== 32'h1010_ABCD) begin
      failures++;
      $display("FAIL rd_wr_both: ack=%b rvalid=%b rdata=%h required 1 1 1010abcd", pio_ack, pio_rvalid, pio_rdata);
    end
    next_div(); tick();
  endtask

  task automatic test_reset_mid();
    logic [NT-1:0] exp_ms;
    exp_ms = '0; exp_ms[3] = 1'b1;
    tgt_rdata[3*PW +: PW] = 32'h3333_0303;
    issue(1'b1, 1'b0, 32'h0003_0000);
    checks++;
    if (tgt_ms !== exp_ms) begin
      failures++; $display("FAIL mid_sel: tgt_ms=%h required %h", tgt_ms, exp_ms);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tgt_ms, pio_ack, pio_rvalid, pio_rdata, pio_err, err_addr, err_cnt, overrun} !== '0) begin
      failures++;
      $display("FAIL mid_reset: tgt_ms=%h ack=%b err_cnt=%0d overrun=%b err_addr=%h required all 0",
               tgt_ms, pio_ack, err_cnt, overrun, err_addr);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    issue(1'b1, 1'b0, 32'h0003_0000);
    next_div();
    tgt_ack[3] = 1'b1;
    tick();
    tgt_ack = '0;
    checks++;
    if (pio_ack !== 1'b1 || pio_err !== 1'b0 || pio_rvalid !== 1'b1 || pio_rdata !== 32'h3333_0303 ||
        err_cnt !== 16'd0 || tgt_ms !== '0) begin
      failures++;
      $display("FAIL after_reset_access: ack=%b err=%b rvalid=%b rdata=%h err_cnt=%0d required 1 0 1 33330303 0",
               pio_ack, pio_err, pio_rvalid, pio_rdata, err_cnt);
    end
    next_div(); tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_overrun();
    test_rd_wr_both();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
